ctu_jbus_clkrst_seq: RTL and testbench
======================================

Name: ctu_jbus_clkrst_seq

Overview:
- Sequences the CTU J-Bus domain cluster headers after power-on.
- Drives each header's cluster_cken, grst_l and gdbginit_l.
- Staggers cluster clock enables to limit di/dt, then holds synchronous reset, then releases it.
- In run mode it services warm-reset, debug-init and clock-stop requests; one sequencer serves NUM_CL cluster headers.

Parameters:
NUM_CL, 4, number of cluster headers controlled
STAGGER, 8, cycles between successive cluster clock-enable (or disable) edges; >=1
RST_CYC, 16, cycles grst_l is held low after clocks are up, or for a warm reset; >=1
DBG_CYC, 4, cycles gdbginit_l is held low for a debug init; >=1
CW, 6, internal counter width; must hold max(NUM_CL*STAGGER, RST_CYC, DBG_CYC)

Ports:
rclk  in  1  sequencer clock (J-Bus cluster rclk)
arst_l  in  1  asynchronous active-low reset
por_done  in  1  level; power-on complete, start sequencing
wrm_rst_req  in  1  level; warm reset request
dbg_init_req  in  1  level; debug init request
stop_req  in  1  level; stop all cluster clocks
cken_mask  in  NUM_CL  per-cluster enable permission
cluster_cken  out  NUM_CL  per-header clock enable
grst_l  out  1  synchronous reset to headers, active-low
gdbginit_l  out  1  debug init to headers, active-low
seq_busy  out  1  sequencer in a transient state
seq_done  out  1  clusters running, resets deasserted

Behaviour:
- Reset values (arst_l low, asynchronous): state OFF; cluster_cken=0, grst_l=0, gdbginit_l=0, seq_busy=0, seq_done=0, counters=0.
- All outputs are registered. seq_busy=1 in every state except OFF and RUN.
- Request priority in RUN: stop_req > wrm_rst_req > dbg_init_req.
- Requests are ignored in all other states. Requesters hold the level until they see seq_done.
- OFF -> CK_UP: at an edge sampling por_done=1 and stop_req=0 (edge E0). Slot counter and idx are cleared.
- CK_UP:
  - cluster_cken[i] is set to cken_mask[i] at edge E0+1+i*STAGGER. The mask bit is sampled at that edge only.
  - Masked clusters still consume their slot, so timing is deterministic.
  - After the last slot's STAGGER cycles -> RST_HOLD.
- RST_HOLD: grst_l=0 for RST_CYC cycles. Then grst_l=1, gdbginit_l=1 and seq_done=1 all at the same edge, and state -> RUN. grst_l rises at E0+1+NUM_CL*STAGGER+RST_CYC.
- RUN: cluster_cken is frozen; cken_mask changes are ignored.
- WRM_RST (from RUN on wrm_rst_req):
  - On entry edge: grst_l=0, gdbginit_l=0, seq_done=0.
  - Clocks stay on.
  - Hold RST_CYC cycles, then restore outputs and -> RUN.
- DBG (from RUN on dbg_init_req):
  - On entry edge: gdbginit_l=0 and seq_done=0; grst_l stays 1.
  - Hold DBG_CYC cycles, then -> RUN.
- CK_DN (from RUN on stop_req):
  - On entry edge: grst_l=0, gdbginit_l=0, seq_done=0.
  - Clear cluster_cken from index NUM_CL-1 down to 0, one every STAGGER cycles. The first clear is at the entry edge +1.
  - After the last slot -> OFF.
- A request still asserted on return to RUN is taken on the next edge. RUN therefore lasts at least 1 cycle, and seq_done pulses high for 1 cycle.
- In OFF, por_done=1 with stop_req=0 restarts sequencing. Requesters drop stop_req to allow it.
- arst_l asserted mid-sequence: every output goes to its reset value immediately, without waiting for rclk.
- Counter wrap is not permitted. Parameter legality is checked with an elaboration-time assertion.

Decomposition:
- Package ctu_clkseq_pkg holds:
  - state enum (OFF, CK_UP, RST_HOLD, RUN, WRM_RST, DBG, CK_DN);
  - default parameter constants;
  - a function computing CW from the parameters.
- One sub-module, ctu_clkseq_cnt: loadable down-counter with a zero flag, shared by all timed states.
- Slot index logic stays in the top module.

Test Plan:
- Power-on: NUM_CL=4, STAGGER=8, RST_CYC=16, mask=4'hF, por_done rises at E0 -> cken bits set at E0+1, +9, +17, +25; grst_l, gdbginit_l and seq_done rise at E0+49; seq_busy high from E0+1 to E0+48.
- Masked cluster: mask=4'b1011 -> cluster_cken ends at 4'b1011; cken[3] rises at E0+25; grst_l still rises at E0+49.
- Warm reset in RUN: wrm_rst_req=1 for one sample -> grst_l=0 for 16 cycles; cluster_cken stays 4'hF; seq_done returns to 1.
- Simultaneous requests in RUN: stop_req, wrm_rst_req and dbg_init_req all =1 -> CK_DN is taken; cken clears in order bit3, bit2, bit1, bit0 every 8 cycles; state ends in OFF; the other requests are ignored.
- Debug init: dbg_init_req pulse in RUN -> gdbginit_l=0 for 4 cycles, grst_l stays 1; a dbg_init_req during CK_UP is ignored.
- Reset mid CK_UP: arst_l low at E0+12 -> cluster_cken=0 with no rclk edge; after release with por_done=1, the sequence restarts from cken[0].

Source files
------------

// File: rtl/ctu_clkseq_pkg.sv
// ---------------------------------------------------------------------------
// ctu_clkseq_pkg
// Shared definitions for the CTU J-Bus cluster clock/reset sequencer:
//   - seq_state_e : sequencer state encoding
//   - DEF_*       : default parameter values
//   - calc_cw()   : minimum counter width for a given parameter set
// ---------------------------------------------------------------------------
package ctu_clkseq_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_CK_UP    = 3'd1,
        ST_RST_HOLD = 3'd2,
        ST_RUN      = 3'd3,
        ST_WRM_RST  = 3'd4,
        ST_DBG      = 3'd5,
        ST_CK_DN    = 3'd6
    } seq_state_e;

    localparam int DEF_NUM_CL  = 4;
    localparam int DEF_STAGGER = 8;
    localparam int DEF_RST_CYC = 16;
    localparam int DEF_DBG_CYC = 4;
    localparam int DEF_CW      = 6;

    // Smallest width that holds max(num_cl*stagger, rst_cyc, dbg_cyc).
    function automatic int calc_cw(input int num_cl, input int stagger,
                                   input int rst_cyc, input int dbg_cyc);
        int m;
        m = num_cl * stagger;
        m = (rst_cyc > m) ? rst_cyc : m;
        m = (dbg_cyc > m) ? dbg_cyc : m;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ctu_jbus_clkrst_seq_if.sv
// ---------------------------------------------------------------------------
// ctu_jbus_clkrst_seq_if
// Request/enable inputs and header-control outputs of the sequencer.
//   master : the sequencer (consumes requests, drives header controls)
//   slave  : requesters / cluster headers
// ---------------------------------------------------------------------------
interface ctu_jbus_clkrst_seq_if
    import ctu_clkseq_pkg::*;
#(
    parameter int NUM_CL = DEF_NUM_CL
);
    logic              por_done;
    logic              wrm_rst_req;
    logic              dbg_init_req;
    logic              stop_req;
    logic [NUM_CL-1:0] cken_mask;
    logic [NUM_CL-1:0] cluster_cken;
    logic              grst_l;
    logic              gdbginit_l;
    logic              seq_busy;
    logic              seq_done;

    modport master (
        input  por_done, wrm_rst_req, dbg_init_req, stop_req, cken_mask,
        output cluster_cken, grst_l, gdbginit_l, seq_busy, seq_done
    );

    modport slave (
        output por_done, wrm_rst_req, dbg_init_req, stop_req, cken_mask,
        input  cluster_cken, grst_l, gdbginit_l, seq_busy, seq_done
    );
endinterface

// File: rtl/ctu_clkseq_cnt.sv
// ---------------------------------------------------------------------------
// ctu_clkseq_cnt
// Loadable down-counter shared by every timed sequencer state. It counts
// down to zero and parks there; load has priority over decrement.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle
//   load_val   : value to load
//   zero       : count is zero
// ---------------------------------------------------------------------------
module ctu_clkseq_cnt
    import ctu_clkseq_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero
);
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: load, else decrement until zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != {CW{1'b0}}) begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/ctu_jbus_clkrst_seq.sv
// ---------------------------------------------------------------------------
// ctu_jbus_clkrst_seq
// Power-on / warm-reset / debug-init / clock-stop sequencer for NUM_CL
// J-Bus cluster headers. Clock enables are staggered STAGGER cycles apart
// to limit di/dt, then grst_l is held for RST_CYC cycles before RUN.
// Ports:
//   rclk   : sequencer clock
//   arst_l : asynchronous active-low reset
//   bus    : requests in (por_done, wrm_rst_req, dbg_init_req, stop_req,
//            cken_mask); header controls out (cluster_cken, grst_l,
//            gdbginit_l, seq_busy, seq_done). All outputs are registered.
// ---------------------------------------------------------------------------
module ctu_jbus_clkrst_seq
    import ctu_clkseq_pkg::*;
#(
    parameter int NUM_CL  = DEF_NUM_CL,
    parameter int STAGGER = DEF_STAGGER,
    parameter int RST_CYC = DEF_RST_CYC,
    parameter int DBG_CYC = DEF_DBG_CYC,
    parameter int CW      = DEF_CW
) (
    input  logic                        rclk,
    input  logic                        arst_l,
    ctu_jbus_clkrst_seq_if.master       bus
);
    // Slot index runs 0..NUM_CL, so it needs one extra code.
    localparam int IW = $clog2(NUM_CL + 1);
    localparam logic [IW-1:0] IDX_END   = IW'(NUM_CL);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [IW-1:0] IDX_ZERO  = IW'(0);
    localparam logic [CW-1:0] LD_ZERO   = CW'(0);
    localparam logic [CW-1:0] LD_STAG   = CW'(STAGGER - 1);
    localparam logic [CW-1:0] LD_RST    = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] LD_DBG    = CW'(DBG_CYC - 1);

    if ((CW < calc_cw(NUM_CL, STAGGER, RST_CYC, DBG_CYC)) ||
        (NUM_CL < 1) || (STAGGER < 1) || (RST_CYC < 1) || (DBG_CYC < 1)) begin : g_bad_params
        $error("ctu_jbus_clkrst_seq: illegal parameter set");
    end

    seq_state_e        state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NUM_CL-1:0] cken_q, cken_d;
    logic              grst_l_q, grst_l_d;
    logic              gdbginit_l_q, gdbginit_l_d;
    logic              seq_busy_q, seq_busy_d;
    logic              seq_done_q, seq_done_d;
    logic              cnt_load_s;
    logic [CW-1:0]     cnt_val_s;
    logic              cnt_zero_s;

    ctu_clkseq_cnt #(.CW(CW)) u_cnt (
        .clk      (rclk),
        .rst_n    (arst_l),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .zero     (cnt_zero_s)
    );

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cken_d       = cken_q;
        grst_l_d     = grst_l_q;
        gdbginit_l_d = gdbginit_l_q;
        seq_done_d   = seq_done_q;
        cnt_load_s   = 1'b0;
        cnt_val_s    = LD_ZERO;
        case (state_q)
            ST_OFF: begin
                if (bus.por_done && !bus.stop_req) begin
                    state_d    = ST_CK_UP;
                    idx_d      = IDX_ZERO;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = LD_ZERO;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_CK_UP: begin
                // One slot per cluster; masked clusters still use their slot.
                if (cnt_zero_s && (idx_q == IDX_END)) begin
                    state_d    = ST_RST_HOLD;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = LD_RST;
                end else if (cnt_zero_s) begin
                    for (int i = 0; i < NUM_CL; i++) begin
                        cken_d[i] = (idx_q == IW'(i)) ? bus.cken_mask[i] : cken_q[i];
                    end
                    idx_d      = idx_q + IDX_ONE;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = LD_STAG;
                end else begin
                    state_d = ST_CK_UP;
                end
            end
            ST_RST_HOLD, ST_WRM_RST, ST_DBG: begin
                if (cnt_zero_s) begin
                    state_d      = ST_RUN;
                    grst_l_d     = 1'b1;
                    gdbginit_l_d = 1'b1;
                    seq_done_d   = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (bus.stop_req) begin
                    state_d      = ST_CK_DN;
                    idx_d        = IDX_END;
                    grst_l_d     = 1'b0;
                    gdbginit_l_d = 1'b0;
                    seq_done_d   = 1'b0;
                    cnt_load_s   = 1'b1;
                    cnt_val_s    = LD_ZERO;
                end else if (bus.wrm_rst_req) begin
                    state_d      = ST_WRM_RST;
                    grst_l_d     = 1'b0;
                    gdbginit_l_d = 1'b0;
                    seq_done_d   = 1'b0;
                    cnt_load_s   = 1'b1;
                    cnt_val_s    = LD_RST;
                end else if (bus.dbg_init_req) begin
                    state_d      = ST_DBG;
                    gdbginit_l_d = 1'b0;
                    seq_done_d   = 1'b0;
                    cnt_load_s   = 1'b1;
                    cnt_val_s    = LD_DBG;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_CK_DN: begin
                // idx counts down; slot idx clears cluster idx-1.
                if (cnt_zero_s && (idx_q == IDX_ZERO)) begin
                    state_d = ST_OFF;
                end else if (cnt_zero_s) begin
                    for (int i = 0; i < NUM_CL; i++) begin
                        cken_d[i] = (idx_q == IW'(i + 1)) ? 1'b0 : cken_q[i];
                    end
                    idx_d      = idx_q - IDX_ONE;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = LD_STAG;
                end else begin
                    state_d = ST_CK_DN;
                end
            end
            default: begin
                state_d      = ST_OFF;
                idx_d        = IDX_ZERO;
                cken_d       = {NUM_CL{1'b0}};
                grst_l_d     = 1'b0;
                gdbginit_l_d = 1'b0;
                seq_done_d   = 1'b0;
            end
        endcase
        seq_busy_d = (state_d != ST_OFF) && (state_d != ST_RUN);
    end

    // State, slot index and registered outputs.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q      <= ST_OFF;
            idx_q        <= IDX_ZERO;
            cken_q       <= {NUM_CL{1'b0}};
            grst_l_q     <= 1'b0;
            gdbginit_l_q <= 1'b0;
            seq_busy_q   <= 1'b0;
            seq_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cken_q       <= cken_d;
            grst_l_q     <= grst_l_d;
            gdbginit_l_q <= gdbginit_l_d;
            seq_busy_q   <= seq_busy_d;
            seq_done_q   <= seq_done_d;
        end
    end

    assign bus.cluster_cken = cken_q;
    assign bus.grst_l       = grst_l_q;
    assign bus.gdbginit_l   = gdbginit_l_q;
    assign bus.seq_busy     = seq_busy_q;
    assign bus.seq_done     = seq_done_q;

endmodule

// File: tb/tb_ctu_jbus_clkrst_seq.sv
// ---------------------------------------------------------------------------
// tb_ctu_jbus_clkrst_seq
// Directed + randomized bench. A time-based reference model tracks the
// current operating phase and the number of cycles spent in it, and derives
// every expected output from the sequencing schedule arithmetic.
// ---------------------------------------------------------------------------
module tb_ctu_jbus_clkrst_seq;
    localparam int N = 4;
    localparam int S = 8;
    localparam int R = 16;
    localparam int D = 4;

    localparam int M_OFF = 0, M_UP = 1, M_RUN = 2, M_WRM = 3, M_DBG = 4, M_DN = 5;

    logic rclk;
    logic arst_l;
    int   n_checks = 0;
    int   n_errors = 0;

    ctu_jbus_clkrst_seq_if #(.NUM_CL(N)) bus ();

    ctu_jbus_clkrst_seq #(
        .NUM_CL(N), .STAGGER(S), .RST_CYC(R), .DBG_CYC(D), .CW(6)
    ) dut (
        .rclk   (rclk),
        .arst_l (arst_l),
        .bus    (bus)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Reference model: phase + cycles since phase entry.
    int          m_mode;
    int          m_k;
    logic [N-1:0] m_cken;

    always @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            m_mode <= M_OFF;
            m_k    <= 0;
            m_cken <= '0;
        end else begin
            case (m_mode)
                M_OFF: begin
                    if (bus.por_done && !bus.stop_req) begin
                        m_mode <= M_UP;
                        m_k    <= 0;
                    end
                end
                M_UP: begin
                    for (int i = 0; i < N; i++)
                        if (m_k + 1 == 1 + i * S) m_cken[i] <= bus.cken_mask[i];
                    if (m_k + 1 == 1 + N * S + R) begin
                        m_mode <= M_RUN;
                        m_k    <= 0;
                    end else m_k <= m_k + 1;
                end
                M_RUN: begin
                    m_k <= 0;
                    if (bus.stop_req) m_mode <= M_DN;
                    else if (bus.wrm_rst_req) m_mode <= M_WRM;
                    else if (bus.dbg_init_req) m_mode <= M_DBG;
                end
                M_WRM: begin
                    if (m_k + 1 == R) begin m_mode <= M_RUN; m_k <= 0; end
                    else m_k <= m_k + 1;
                end
                M_DBG: begin
                    if (m_k + 1 == D) begin m_mode <= M_RUN; m_k <= 0; end
                    else m_k <= m_k + 1;
                end
                M_DN: begin
                    for (int j = 0; j < N; j++)
                        if (m_k + 1 == 1 + (N - 1 - j) * S) m_cken[j] <= 1'b0;
                    if (m_k + 1 == 1 + N * S) begin m_mode <= M_OFF; m_k <= 0; end
                    else m_k <= m_k + 1;
                end
                default: m_mode <= M_OFF;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        logic e_grst, e_dbg, e_busy, e_done;
        case (m_mode)
            M_UP:    begin e_grst = 1'b0; e_dbg = 1'b0; e_busy = 1'b1; e_done = 1'b0; end
            M_RUN:   begin e_grst = 1'b1; e_dbg = 1'b1; e_busy = 1'b0; e_done = 1'b1; end
            M_WRM:   begin e_grst = 1'b0; e_dbg = 1'b0; e_busy = 1'b1; e_done = 1'b0; end
            M_DBG:   begin e_grst = 1'b1; e_dbg = 1'b0; e_busy = 1'b1; e_done = 1'b0; end
            M_DN:    begin e_grst = 1'b0; e_dbg = 1'b0; e_busy = 1'b1; e_done = 1'b0; end
            default: begin e_grst = 1'b0; e_dbg = 1'b0; e_busy = 1'b0; e_done = 1'b0; end
        endcase
        chk({ph, ".cken"}, 32'(bus.cluster_cken), 32'(m_cken));
        chk({ph, ".grst_l"}, 32'(bus.grst_l), 32'(e_grst));
        chk({ph, ".gdbginit_l"}, 32'(bus.gdbginit_l), 32'(e_dbg));
        chk({ph, ".seq_busy"}, 32'(bus.seq_busy), 32'(e_busy));
        chk({ph, ".seq_done"}, 32'(bus.seq_done), 32'(e_done));
    endtask

    task automatic step(input string ph);
        @(posedge rclk);
        @(negedge rclk);
        check_all(ph);
    endtask

    task automatic wait_done(input string ph, input int budget, output int n);
        n = 0;
        do begin
            step(ph);
            n++;
        end while (bus.seq_done !== 1'b1 && n < budget);
    endtask

    task automatic check_zero_outputs(input string ph);
        chk({ph, ".cken0"}, 32'(bus.cluster_cken), 32'd0);
        chk({ph, ".grst0"}, 32'(bus.grst_l), 32'd0);
        chk({ph, ".dbg0"}, 32'(bus.gdbginit_l), 32'd0);
        chk({ph, ".busy0"}, 32'(bus.seq_busy), 32'd0);
        chk({ph, ".done0"}, 32'(bus.seq_done), 32'd0);
    endtask

    initial begin
        int n;
        int low;
        int clr_at [N];

        arst_l           = 1'b0;
        bus.por_done     = 1'b0;
        bus.wrm_rst_req  = 1'b0;
        bus.dbg_init_req = 1'b0;
        bus.stop_req     = 1'b0;
        bus.cken_mask    = '0;
        #1;
        check_zero_outputs("reset");
        step("reset");
        step("reset");
        arst_l = 1'b1;
        repeat (3) step("off");

        // Power-on, all clusters enabled; a debug request during CK_UP is ignored.
        bus.cken_mask    = 4'hF;
        bus.por_done     = 1'b1;
        bus.dbg_init_req = 1'b1;
        repeat (20) step("po1");
        bus.dbg_init_req = 1'b0;
        wait_done("po1", 100, n);
        chk("po1.latency", 32'(20 + n), 32'd50);
        chk("po1.cken_final", 32'(bus.cluster_cken), 32'hF);

        // Warm reset, one-sample request.
        bus.wrm_rst_req = 1'b1;
        low = 0;
        for (int i = 0; i < 21; i++) begin
            step("wrm");
            bus.wrm_rst_req = 1'b0;
            if (bus.grst_l === 1'b0) low++;
        end
        chk("wrm.low_cycles", 32'(low), 32'(R));
        chk("wrm.done_back", 32'(bus.seq_done), 32'd1);
        chk("wrm.cken_kept", 32'(bus.cluster_cken), 32'hF);

        // Debug init, one-sample request.
        bus.dbg_init_req = 1'b1;
        low = 0;
        for (int i = 0; i < 8; i++) begin
            step("dbg");
            bus.dbg_init_req = 1'b0;
            if (bus.gdbginit_l === 1'b0) low++;
        end
        chk("dbg.low_cycles", 32'(low), 32'(D));

        // All requests together: stop wins, clocks clear from the top down.
        bus.stop_req     = 1'b1;
        bus.wrm_rst_req  = 1'b1;
        bus.dbg_init_req = 1'b1;
        for (int j = 0; j < N; j++) clr_at[j] = -1;
        for (int i = 1; i <= 38; i++) begin
            step("stop");
            for (int j = 0; j < N; j++)
                if (clr_at[j] < 0 && bus.cluster_cken[j] === 1'b0) clr_at[j] = i;
        end
        for (int j = 0; j < N; j++)
            chk($sformatf("stop.clr_step%0d", j), 32'(clr_at[j]), 32'(2 + (N - 1 - j) * S));
        check_zero_outputs("stop.off");

        // Restart with cluster 2 masked off.
        bus.stop_req     = 1'b0;
        bus.wrm_rst_req  = 1'b0;
        bus.dbg_init_req = 1'b0;
        bus.cken_mask    = 4'b1011;
        wait_done("po_mask", 100, n);
        chk("po_mask.latency", 32'(n), 32'd50);
        chk("po_mask.cken_final", 32'(bus.cluster_cken), 32'hB);

        // Power-on with the mask changing every cycle.
        bus.stop_req = 1'b1;
        repeat (36) step("stop2");
        bus.stop_req = 1'b0;
        n = 0;
        do begin
            bus.cken_mask = N'($urandom);
            step("po_rand");
            n++;
        end while (bus.seq_done !== 1'b1 && n < 100);
        chk("po_rand.latency", 32'(n), 32'd50);

        // Asynchronous reset in the middle of CK_UP.
        bus.cken_mask = 4'hF;
        bus.stop_req  = 1'b1;
        repeat (36) step("stop3");
        bus.stop_req = 1'b0;
        repeat (13) step("up_mid");
        chk("up_mid.cken_before", 32'(bus.cluster_cken), 32'h3);
        #2 arst_l = 1'b0;
        #1;
        check_zero_outputs("arst_mid");
        step("arst_hold");
        step("arst_hold");
        arst_l = 1'b1;
        step("restart");
        step("restart");
        chk("restart.cken0_first", 32'(bus.cluster_cken), 32'h1);
        wait_done("restart", 100, n);
        chk("restart.latency", 32'(n + 2), 32'd50);

        // Randomized request traffic.
        for (int i = 0; i < 400; i++) begin
            bus.por_done     = ($urandom_range(0, 9) != 0);
            bus.stop_req     = ($urandom_range(0, 39) == 0);
            bus.wrm_rst_req  = ($urandom_range(0, 11) == 0);
            bus.dbg_init_req = ($urandom_range(0, 11) == 0);
            bus.cken_mask    = N'($urandom);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
